fft_kmul_sched: RTL and testbench

FFT_KMUL_SCHED -- requirements
Module: fft_kmul_sched

---
 rtl/fft_kmul_sched.sv | 176 +++++++++++++++++
 tb/tb_fft_kmul_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_kmul_sched.sv
// rtl/fft_kmul_sched.sv - complex sample x twiddle multiplier, three passes through one shared multiply-add
module fft_kmul_sched #(
    parameter int DATA_WIDTH    = 25,
    parameter int TWIDDLE_WIDTH = 10,
    parameter int NLOG2         = 10
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [NLOG2-1:0]                ctr_i,
    input  logic signed [DATA_WIDTH-1:0]    x_re_i,
    input  logic signed [DATA_WIDTH-1:0]    x_im_i,
    input  logic signed [TWIDDLE_WIDTH-1:0] w_re_i,
    input  logic signed [TWIDDLE_WIDTH-1:0] w_im_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [NLOG2-1:0]                ctr_o,
    output logic signed [DATA_WIDTH-1:0]    z_re_o,
    output logic signed [DATA_WIDTH-1:0]    z_im_o
);

    // P width of the multiply-add, A and B operand widths, kept-result width
    localparam int PW = DATA_WIDTH + TWIDDLE_WIDTH + 1;
    localparam int AW = DATA_WIDTH + 1;
    localparam int BW = TWIDDLE_WIDTH + 1;
    localparam int KW = DATA_WIDTH + TWIDDLE_WIDTH - 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_F = 3'd1,
        MUL_R = 3'd2,
        MUL_I = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    // latched operands and partial products
    logic signed [DATA_WIDTH-1:0]    x_re;
    logic signed [DATA_WIDTH-1:0]    x_im;
    logic signed [TWIDDLE_WIDTH-1:0] w_re;
    logic signed [TWIDDLE_WIDTH-1:0] w_im;
    logic [NLOG2-1:0]                ctr;
    logic signed [PW-1:0]            f;
    logic [KW-1:0]                   r;

    // shared multiply-add P = A*B + C
    logic signed [AW-1:0] mul_a;
    logic signed [BW-1:0] mul_b;
    logic signed [PW-1:0] mul_c;
    logic signed [PW-1:0] mul_a_ext;
    logic signed [PW-1:0] mul_b_ext;
    logic signed [PW-1:0] mul_p;

    logic accept;

    // round half-to-even of p / 2^(TWIDDLE_WIDTH-1); bits above KW-1 are dropped, so the result wraps
    function automatic logic [DATA_WIDTH-1:0] rnd(input logic [KW-1:0] p);
        logic [DATA_WIDTH-1:0] t;
        logic                  half;
        logic                  sticky;
        t      = p[KW-1:TWIDDLE_WIDTH-1];
        half   = p[TWIDDLE_WIDTH-2];
        sticky = |p[TWIDDLE_WIDTH-3:0];
        return t + {{(DATA_WIDTH-1){1'b0}}, half & (sticky | t[0])};
    endfunction

    assign in_ready_o = !rst_i && ((state == IDLE) || ((state == HOLD) && out_ready_i));
    assign accept     = in_valid_i && in_ready_o;

    // state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state: one pass per product, then hold until the result is taken
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = accept ? MUL_F : IDLE;
            MUL_F:   state_next = MUL_R;
            MUL_R:   state_next = MUL_I;
            MUL_I:   state_next = HOLD;
            HOLD: begin
                if (out_ready_i) begin
                    state_next = accept ? MUL_F : IDLE;
                end else begin
                    state_next = HOLD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // operand select: f=(xr-xi)*wr, r=xi*(wr-wi)+f, i=xr*(wr+wi)-f
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        mul_c = '0;
        case (state)
            MUL_F: begin
                mul_a = {x_re[DATA_WIDTH-1], x_re} - {x_im[DATA_WIDTH-1], x_im};
                mul_b = {w_re[TWIDDLE_WIDTH-1], w_re};
            end
            MUL_R: begin
                mul_a = {x_im[DATA_WIDTH-1], x_im};
                mul_b = {w_re[TWIDDLE_WIDTH-1], w_re} - {w_im[TWIDDLE_WIDTH-1], w_im};
                mul_c = f;
            end
            MUL_I: begin
                mul_a = {x_re[DATA_WIDTH-1], x_re};
                mul_b = {w_re[TWIDDLE_WIDTH-1], w_re} + {w_im[TWIDDLE_WIDTH-1], w_im};
                mul_c = -f;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
                mul_c = '0;
            end
        endcase
    end

    // all arithmetic is modulo 2^PW; the true results always fit, so wrap of intermediates is harmless
    assign mul_a_ext = PW'(mul_a);
    assign mul_b_ext = PW'(mul_b);
    assign mul_p     = mul_a_ext * mul_b_ext + mul_c;

    // operand capture, partial products and the held result
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_re        <= '0;
            x_im        <= '0;
            w_re        <= '0;
            w_im        <= '0;
            ctr         <= '0;
            f           <= '0;
            r           <= '0;
            z_re_o      <= '0;
            z_im_o      <= '0;
            ctr_o       <= '0;
            out_valid_o <= 1'b0;
        end else begin
            if (accept) begin
                x_re <= x_re_i;
                x_im <= x_im_i;
                w_re <= w_re_i;
                w_im <= w_im_i;
                ctr  <= ctr_i;
            end
            case (state)
                MUL_F: f <= mul_p;
                MUL_R: r <= mul_p[KW-1:0];
                MUL_I: begin
                    z_re_o      <= rnd(r);
                    z_im_o      <= rnd(mul_p[KW-1:0]);
                    ctr_o       <= ctr;
                    out_valid_o <= 1'b1;
                end
                HOLD: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_kmul_sched.sv
// tb/tb_fft_kmul_sched.sv - self-checking bench for fft_kmul_sched
module tb_fft_kmul_sched;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [9:0]         ctr_in;
    logic signed [24:0] x_re;
    logic signed [24:0] x_im;
    logic signed [9:0]  w_re;
    logic signed [9:0]  w_im;
    logic               out_valid;
    logic               out_ready;
    logic [9:0]         ctr_out;
    logic signed [24:0] z_re;
    logic signed [24:0] z_im;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint xr;
        longint xi;
        longint wr;
        longint wi;
        longint c;
        longint er;
        longint ei;
    } vec_t;

    fft_kmul_sched #(
        .DATA_WIDTH(25),
        .TWIDDLE_WIDTH(10),
        .NLOG2(10)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .ctr_i(ctr_in),
        .x_re_i(x_re),
        .x_im_i(x_im),
        .w_re_i(w_re),
        .w_im_i(w_im),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .ctr_o(ctr_out),
        .z_re_o(z_re),
        .z_im_o(z_im)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // exact complex product, divided by 512 with ties to even, wrapped to 25-bit signed
    function automatic longint model_rnd(input longint p);
        longint q;
        longint rem;
        q   = p >>> 9;
        rem = p - q * 512;
        if (rem > 256 || (rem == 256 && q[0])) q = q + 1;
        q = q & 64'h1FF_FFFF;
        if (q >= 64'h100_0000) q = q - 64'h200_0000;
        return q;
    endfunction

    function automatic vec_t model(input longint xr, xi, wr, wi, c);
        vec_t v;
        v.xr = xr; v.xi = xi; v.wr = wr; v.wi = wi; v.c = c;
        v.er = model_rnd(xr * wr - xi * wi);
        v.ei = model_rnd(xr * wi + xi * wr);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        logic signed [24:0] a;
        logic signed [24:0] b;
        logic signed [9:0]  p;
        logic signed [9:0]  q;
        a = 25'($urandom);
        b = 25'($urandom);
        p = 10'($urandom);
        q = 10'($urandom);
        return model(a, b, p, q, longint'($urandom_range(0, 1023)));
    endfunction

    task automatic drive(input vec_t v);
        x_re     = 25'(v.xr);
        x_im     = 25'(v.xi);
        w_re     = 10'(v.wr);
        w_im     = 10'(v.wi);
        ctr_in   = 10'(v.c);
        in_valid = 1'b1;
    endtask

    task automatic scramble();
        x_re     = 25'($urandom);
        x_im     = 25'($urandom);
        w_re     = 10'($urandom);
        w_im     = 10'($urandom);
        ctr_in   = 10'($urandom);
        in_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_ready"}, longint'(in_ready), 1);
    endtask

    task automatic wait_result(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_latency"}, n, 3);
    endtask

    task automatic check_out(input string name, input vec_t v);
        chk({name, "_zre"}, longint'(z_re), v.er);
        chk({name, "_zim"}, longint'(z_im), v.ei);
        chk({name, "_ctr"}, longint'(ctr_out), v.c);
    endtask

    task automatic run_sample(input vec_t v, input string name);
        drive(v);
        wait_ready(name);
        @(posedge clk); #1;
        scramble();
        wait_result(name);
        check_out(name, v);
        @(posedge clk); #1;
    endtask

    vec_t table_v[8];
    vec_t stream_v[8];
    vec_t va;
    vec_t vb;

    initial begin
        int cnt;
        int got;
        int k;
        int cyc;
        int last;
        int bad_rdy;
        int bad_out;
        logic hs;
        logic signed [24:0] cap_re;
        logic signed [24:0] cap_im;
        logic [9:0]         cap_ctr;

        table_v[0] = '{1000, -2000, 511, 0, 5, 998, -1996};
        table_v[1] = '{1, 0, 256, 0, 1, 0, 0};
        table_v[2] = '{3, 0, 256, 0, 2, 2, 0};
        table_v[3] = '{-1, 0, 256, 0, 3, 0, 0};
        table_v[4] = '{-3, 0, 256, 0, 4, -2, 0};
        table_v[5] = '{100, 200, 0, -512, 6, 200, -100};
        table_v[6] = '{7, 0, 256, 0, 1023, 4, 0};
        table_v[7] = '{-16777216, 0, -512, 0, 9, -16777216, 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_re = '0; x_im = '0; w_re = '0; w_im = '0; ctr_in = '0;

        // reset state before any clock edge
        #2;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_zre", longint'(z_re), 0);
        chk("rst_zim", longint'(z_im), 0);
        chk("rst_ctr", longint'(ctr_out), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("release_in_ready", longint'(in_ready), 1);

        // directed vectors
        for (int i = 0; i < 8; i++) begin
            run_sample(table_v[i], $sformatf("vec%0d", i));
        end

        // random vectors against the model
        for (int i = 0; i < 30; i++) begin
            run_sample(rand_vec(), $sformatf("rand%0d", i));
        end

        // backpressure: result held for 10 clocks with a new sample waiting
        va = rand_vec();
        vb = rand_vec();
        out_ready = 1'b0;
        drive(va);
        wait_ready("bp_a");
        @(posedge clk); #1;
        scramble();
        wait_result("bp_a");
        check_out("bp_a", va);
        cap_re = z_re; cap_im = z_im; cap_ctr = ctr_out;
        drive(vb);
        bad_rdy = 0;
        bad_out = 0;
        for (int i = 0; i < 10; i++) begin
            if (in_ready) bad_rdy++;
            if (!out_valid || z_re != cap_re || z_im != cap_im || ctr_out != cap_ctr) bad_out++;
            @(posedge clk); #1;
        end
        chk("bp_ready_low", bad_rdy, 0);
        chk("bp_stable", bad_out, 0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", longint'(in_ready), 1);
        @(posedge clk); #1;
        scramble();
        chk("bp_valid_drop", longint'(out_valid), 0);
        wait_result("bp_b");
        check_out("bp_b", vb);
        @(posedge clk); #1;

        // back-to-back stream of 8 with in_valid held
        for (int i = 0; i < 8; i++) begin
            stream_v[i] = rand_vec();
            stream_v[i].c = 100 + i;
        end
        k = 0; got = 0; cyc = 0; last = 0;
        drive(stream_v[0]);
        while (got < 8 && cyc < 100) begin
            hs = in_valid && in_ready;
            if (out_valid) begin
                check_out($sformatf("stream%0d", got), stream_v[got]);
                if (got > 0) chk($sformatf("stream%0d_spacing", got), cyc - last, 4);
                last = cyc;
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                k++;
                if (k < 8) drive(stream_v[k]);
                else scramble();
            end
        end
        chk("stream_count", got, 8);
        @(posedge clk); #1;

        // reset while holding a result clears outputs without a clock edge
        out_ready = 1'b0;
        va = model(12345, -678, 300, -200, 77);
        drive(va);
        wait_ready("rh");
        @(posedge clk); #1;
        scramble();
        wait_result("rh");
        #2;
        rst = 1'b1;
        #1;
        chk("rh_out_valid", longint'(out_valid), 0);
        chk("rh_zre", longint'(z_re), 0);
        chk("rh_ctr", longint'(ctr_out), 0);
        chk("rh_in_ready", longint'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rh_release_ready", longint'(in_ready), 1);

        // reset during MUL_R discards the sample
        drive(rand_vec());
        wait_ready("rr");
        @(posedge clk); #1;
        scramble();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rr_out_valid", longint'(out_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) cnt++;
            @(posedge clk); #1;
        end
        chk("rr_no_stale", cnt, 0);
        run_sample(rand_vec(), "rr_next");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
